// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// It takes one input snapshot per scan frame and blanks every anode at the start of each digit slot.
module seven_seg_scanner #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       digit0_en_i,
    input  logic       digit1_en_i,
    input  logic       digit2_en_i,
    input  logic       digit3_en_i,
    input  logic [3:0] digit0_i,
    input  logic [3:0] digit1_i,
    input  logic [3:0] digit2_i,
    input  logic [3:0] digit3_i,
    output logic [3:0] anode_o,
    output logic [6:0] segments_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    // Active-low cathodes, bit order g,f,e,d,c,b,a.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_idx;
    logic [3:0]      r_snap_en;
    logic [3:0][3:0] r_snap_nib;
    logic [3:0]      r_anode;
    logic [6:0]      r_seg;

    logic            w_frame_start;
    logic            w_lit;
    logic [3:0]      w_anode_sel;

    assign w_frame_start = (r_cnt == '0) && (r_idx == 2'd0);
    assign w_lit         = (r_cnt >= CNT_BLANK) && r_snap_en[r_idx];
    assign w_anode_sel   = ~(4'b0001 << r_idx);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_idx      <= 2'd0;
            r_snap_en  <= 4'h0;
            r_snap_nib <= '0;
            r_anode    <= 4'hF;
            r_seg      <= 7'h7F;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Whole-frame snapshot so a frame never mixes old and new digits.
            if (w_frame_start) begin
                r_snap_en  <= {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
                r_snap_nib <= {digit3_i, digit2_i, digit1_i, digit0_i};
            end

            if (w_lit) begin
                r_anode <= w_anode_sel;
                r_seg   <= hex_decode(r_snap_nib[r_idx]);
            end else begin
                r_anode <= 4'hF;
                r_seg   <= 7'h7F;
            end
        end
    end

    assign anode_o    = r_anode;
    assign segments_o = r_seg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with SCAN_DIV=8, BLANK_CYCLES=2.
// Expected per-cycle {anode, segments} words are queued per frame and popped as the DUT runs.
module tb_seven_seg_scanner;

    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en0 = 1'b0, en1 = 1'b0, en2 = 1'b0, en3 = 1'b0;
    logic [3:0] d0 = 4'h0, d1 = 4'h0, d2 = 4'h0, d3 = 4'h0;
    logic [3:0] anode;
    logic [6:0] seg;

    logic [10:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    int          blank_run = 0;

    seven_seg_scanner #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .digit0_en_i(en0),
        .digit1_en_i(en1),
        .digit2_en_i(en2),
        .digit3_en_i(en3),
        .digit0_i   (d0),
        .digit1_i   (d1),
        .digit2_i   (d2),
        .digit3_i   (d3),
        .anode_o    (anode),
        .segments_o (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000; 4'h1: s = 7'b1111001; 4'h2: s = 7'b0100100; 4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001; 4'h5: s = 7'b0010010; 4'h6: s = 7'b0000010; 4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000; 4'h9: s = 7'b0010000; 4'hA: s = 7'b0001000; 4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110; 4'hD: s = 7'b0100001; 4'hE: s = 7'b0000110; default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    task automatic set_inputs(input logic [3:0] en, input logic [3:0] n0, input logic [3:0] n1,
                              input logic [3:0] n2, input logic [3:0] n3);
        {en3, en2, en1, en0} = en;
        d0 = n0; d1 = n1; d2 = n2; d3 = n3;
    endtask

    // One frame of expected output: 2 blank cycles then 6 lit (or blank if disabled) per slot.
    task automatic push_frame(input logic [3:0] en, input logic [3:0] n0, input logic [3:0] n1,
                              input logic [3:0] n2, input logic [3:0] n3);
        logic [3:0] nib [4];
        logic [3:0] an;
        nib[0] = n0; nib[1] = n1; nib[2] = n2; nib[3] = n3;
        for (int d = 0; d < 4; d++) begin
            an = 4'hF;
            an[d] = 1'b0;
            for (int c = 0; c < SCAN_DIV; c++) begin
                if (c < BLANK_CYCLES || !en[d]) exp_q.push_back({4'hF, 7'h7F});
                else exp_q.push_back({an, ref_seg(nib[d])});
            end
        end
    endtask

    // Whole-run invariants: one-hot-or-none anodes, and a blank run of at least
    // BLANK_CYCLES before any anode goes low.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ($countones(~anode) > 1) begin
                n_fail++;
                $display("FAIL onehot_anode t=%0t anode=%b required at most one low", $time, anode);
            end
            if (anode !== 4'hF) begin
                n_checks++;
                if (blank_run > 0 && blank_run < BLANK_CYCLES) begin
                    n_fail++;
                    $display("FAIL blank_gap t=%0t blank_run=%0d required>=%0d", $time, blank_run, BLANK_CYCLES);
                end
                blank_run = 0;
            end else begin
                blank_run++;
            end
        end
    end

    task automatic test_reset();
        logic [10:0] exp;
        set_inputs(4'hF, 4'h0, 4'h1, 4'h2, 4'h3);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({anode, seg} !== {4'hF, 7'h7F}) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got=%b_%b required=1111_1111111", c, anode, seg);
            end
            mon_en = 1'b1;
        end
        rst = 1'b0;
        push_frame(4'hF, 4'h0, 4'h1, 4'h2, 4'h3);
        for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({anode, seg} !== exp) begin
                n_fail++;
                $display("FAIL first_frame cyc=%0d got=%b_%b required=%b_%b", c, anode, seg, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_disable();
        logic [10:0] exp;
        set_inputs(4'b1011, 4'h8, 4'h1, 4'h2, 4'h3);
        push_frame(4'b1011, 4'h8, 4'h1, 4'h2, 4'h3);
        for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({anode, seg} !== exp) begin
                n_fail++;
                $display("FAIL digit2_disabled cyc=%0d got=%b_%b required=%b_%b", c, anode, seg, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_midframe_update();
        logic [10:0] exp;
        set_inputs(4'hF, 4'h8, 4'h1, 4'h2, 4'h3);
        push_frame(4'hF, 4'h8, 4'h1, 4'h2, 4'h3);
        push_frame(4'hF, 4'hF, 4'h1, 4'h2, 4'h3);
        for (int c = 0; c < 8 * SCAN_DIV; c++) begin
            if (c == SCAN_DIV + BLANK_CYCLES + 3) d0 = 4'hF;
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({anode, seg} !== exp) begin
                n_fail++;
                $display("FAIL midframe_update cyc=%0d got=%b_%b required=%b_%b", c, anode, seg, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] exp;
        set_inputs(4'hF, 4'h5, 4'hA, 4'h9, 4'h4);
        push_frame(4'hF, 4'h5, 4'hA, 4'h9, 4'h4);
        for (int c = 0; c < 2 * SCAN_DIV + BLANK_CYCLES + 3; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({anode, seg} !== exp) begin
                n_fail++;
                $display("FAIL pre_reset cyc=%0d got=%b_%b required=%b_%b", c, anode, seg, exp[10:7], exp[6:0]);
            end
        end
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({anode, seg} !== {4'hF, 7'h7F}) begin
            n_fail++;
            $display("FAIL midframe_reset got=%b_%b required=1111_1111111", anode, seg);
        end
        rst = 1'b0;
        set_inputs(4'hF, 4'hC, 4'hD, 4'hE, 4'h6);
        push_frame(4'hF, 4'hC, 4'hD, 4'hE, 4'h6);
        for (int c = 0; c < 4 * SCAN_DIV; c++) begin
            @(posedge clk); #1;
            exp = exp_q.pop_front();
            n_checks++;
            if ({anode, seg} !== exp) begin
                n_fail++;
                $display("FAIL post_reset_restart cyc=%0d got=%b_%b required=%b_%b", c, anode, seg, exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic test_sweep();
        logic [10:0] exp;
        logic [3:0]  v;
        logic [3:0]  n1;
        for (int f = 0; f < 16; f++) begin
            v  = 4'(f);
            n1 = 4'($urandom_range(0, 15));
            set_inputs(4'hF, v, n1, ~v, 4'h7);
            push_frame(4'hF, v, n1, ~v, 4'h7);
            for (int c = 0; c < 4 * SCAN_DIV; c++) begin
                @(posedge clk); #1;
                exp = exp_q.pop_front();
                n_checks++;
                if ({anode, seg} !== exp) begin
                    n_fail++;
                    $display("FAIL nibble_sweep val=%h cyc=%0d got=%b_%b required=%b_%b", v, c, anode, seg, exp[10:7], exp[6:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_disable();
        test_midframe_update();
        test_reset_midframe();
        test_sweep();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It sits directly downstream of the game top level and consumes its four `digitN_o` nibbles and `digitN_en_o` enables. It latches them once per scan frame and hex-decodes the active digit. It then drives one anode at a time, with an inter-digit blanking gap so no ghost image appears on the next digit.

## Interface
- `SCAN_DIV`, default 25000: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYCLES`, default 64: cycles at the start of each slot with every anode off. Range is 1 ≤ BLANK_CYCLES < SCAN_DIV.
- `clk_i`  in  1: display clock. All inputs are synchronous to it.
- `rst_i`  in  1: reset, synchronous, active-high.
- `digit0_en_i`..`digit3_en_i`  in  1 each: per-digit enable. 1 means the digit is lit.
- `digit0_i`..`digit3_i`  in  4 each: per-digit hex value.
- `anode_o`  out  4: active-low anode select. Bit n drives digit n.
- `segments_o`  out  7: active-low cathodes, ordered [6:0] = g,f,e,d,c,b,a.

## Operation
- Slot counter `cnt` has width $clog2(SCAN_DIV) and counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and the 2-bit digit index `idx` increments.
  - `idx` wraps from 3 to 0.
  - Otherwise `cnt` increments every cycle.
- Frame snapshot:
  - All 4 enables and 4 nibbles are captured together in the cycle where cnt==0 and idx==0.
  - This includes the first cycle after reset is released.
  - Inputs that change mid-frame take effect only at the next frame boundary, so a frame never shows a partial update.
- Blanking rule: when cnt < BLANK_CYCLES, or when the snapshot enable for `idx` is 0:
  - anode_o = 4'hF;
  - segments_o = 7'h7F.
- Lit rule (all other cases):
  - anode_o has bit `idx` low and all other bits high;
  - segments_o = decode(snapshot nibble[idx]).
- Hex decode, full 0..F, in standard segment shapes. Reference codes (g..a):
  - 0 = 1000000
  - 1 = 1111001
  - 5 = 0010010
  - 8 = 0000000
  - A = 0001000
  - F = 0001110
- No other states exist. The scan runs free whenever the block is out of reset.

## Timing
- Reset:
  - anode_o = 4'hF and segments_o = 7'h7F on the cycle after any rst_i-high edge.
  - cnt = 0, idx = 0, snapshot cleared (all enables 0, nibbles 0).
  - Reset asserted mid-slot or mid-frame has the same effect: outputs are blank from the next edge and the scan restarts at digit 0.
- anode_o and segments_o are registered, with 1-cycle latency from (cnt, idx, snapshot). The two outputs always change on the same edge, never skewed.
- Snapshot latency:
  - The snapshot loads at cnt==0 and idx==0.
  - The first output cycle that can use it falls in digit 0's blanking window, because BLANK_CYCLES ≥ 1.
  - New values are therefore visible no later than BLANK_CYCLES+1 cycles after the frame boundary.
- Per slot: BLANK_CYCLES cycles blank, then SCAN_DIV-BLANK_CYCLES cycles lit (if enabled).
- Per frame: 4·SCAN_DIV cycles.
- At most one anode is ever low. When idx changes, all anodes are high for at least BLANK_CYCLES cycles before the new anode goes low.
- Simultaneous events:
  - An input change in the snapshot cycle is captured, because the snapshot samples the value present at that edge.
  - rst_i overrides counting and snapshot load.

## Test plan
All scenarios use SCAN_DIV=8 and BLANK_CYCLES=2.

1. Reset, then release with all enables 1 and nibbles 3,2,1,0 (digit3..digit0):
   - anode_o cycles 1110→1101→1011→0111, each lit 6 cycles with 2 blank cycles before it;
   - segments_o = 1000000, 1111001, 0100100, 0110000 for digits 0..3 in that order;
   - frame period is 32 cycles.
2. Set digit2_en_i=0 with the others at 1:
   - the digit-2 slot is blank for all 8 cycles (anode_o=1111, segments_o=1111111);
   - the other slots are unchanged.
3. Change digit0_i from 8 to F while the digit-1 slot is active:
   - digit 0 keeps showing 0000000 for the rest of the frame;
   - from the next frame, digit 0 shows 0001110.
4. Assert rst_i for 1 cycle during the digit-2 lit window:
   - next cycle: anode_o=1111, segments_o=1111111;
   - after release, the scan restarts at digit 0, with 2 blank cycles then anode_o=1110.
5. Sweep nibble 0..F on digit 0 across 16 frames: segments_o matches the decode for all 16 values.
6. Across the whole run, check on every cycle:
   - at most one anode_o bit is low;
   - no anode-low cycle occurs in the first 2 cycles of any slot.
